// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with one-hot registered grant, tenure hold limit and
// back-to-back handoff. A release rotates priority past the outgoing owner.
module onehot_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o,
  output logic [7:0]       hold_cnt_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, eff_ptr;
  logic [IDX_W-1:0] sel_idx, idx_nxt;
  logic             sel_any, rel;
  logic [7:0]       hold_nxt;
  logic [N-1:0]     grant_nxt;

  assign rel = (state == GRANT) &&
               (done_i || !req_i[grant_idx_o] || hold_cnt_o == 8'(MAX_HOLD));

  // A release rotates priority before selection, so the same-cycle request
  // vector is searched from the slot after the outgoing owner.
  assign eff_ptr = rel ? IDX_W'((int'(grant_idx_o) + 1) % N) : ptr;

  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(eff_ptr) + k) % N;
      if (!sel_any && req_i[j]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = grant_idx_o;
    hold_nxt  = hold_cnt_o;
    case (state)
      IDLE: begin
        if (sel_any) begin
          state_nxt = GRANT;
          idx_nxt   = sel_idx;
          hold_nxt  = 8'd1;
        end
      end
      GRANT: begin
        if (!rel) begin
          hold_nxt = hold_cnt_o + 8'd1;
        end else begin
          ptr_nxt = eff_ptr;
          if (sel_any) begin
            idx_nxt  = sel_idx;
            hold_nxt = 8'd1;
          end else begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            hold_nxt  = 8'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    grant_nxt = '0;
    if (state_nxt == GRANT) grant_nxt[idx_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_idx_o   <= '0;
      hold_cnt_o    <= 8'd0;
      grant_o       <= '0;
      grant_valid_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      grant_idx_o   <= idx_nxt;
      hold_cnt_o    <= hold_nxt;
      grant_o       <= grant_nxt;
      grant_valid_o <= (state_nxt == GRANT);
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench: a behavioural model pushes expected outputs per driven
// cycle; they are popped and compared one cycle later.
module tb_onehot_rr_arbiter;
  localparam int N = 4, IDX_W = 2, MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_i;
  logic             done_i;
  logic [N-1:0]     grant_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             grant_valid_o;
  logic [7:0]       hold_cnt_o;

  onehot_rr_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .done_i(done_i),
    .grant_o(grant_o), .grant_idx_o(grant_idx_o),
    .grant_valid_o(grant_valid_o), .hold_cnt_o(hold_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     g;
    logic [IDX_W-1:0] idx;
    logic             v;
    logic [7:0]       h;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;

  bit m_v   = 0;
  int m_idx = 0, m_hold = 0, m_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, then compare DUT against the oldest entry.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic d);
    bit   rel;
    int   found;
    exp_t e;
    rst_n = r; req_i = rq; done_i = d;
    if (!r) begin
      m_v = 0; m_idx = 0; m_hold = 0; m_ptr = 0;
    end else begin
      rel = m_v && (d || !rq[m_idx] || m_hold == MAX_HOLD);
      if (m_v && !rel) begin
        m_hold++;
      end else begin
        if (rel) m_ptr = (m_idx + 1) % N;
        found = -1;
        for (int k = 0; k < N; k++)
          if (found < 0 && rq[(m_ptr + k) % N]) found = (m_ptr + k) % N;
        if (found >= 0) begin
          m_v = 1; m_idx = found; m_hold = 1;
        end else begin
          m_v = 0; m_idx = 0; m_hold = 0;
        end
      end
    end
    e.g   = m_v ? N'(1 << m_idx) : '0;
    e.idx = IDX_W'(m_idx);
    e.v   = m_v;
    e.h   = 8'(m_hold);
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("grant", 32'(grant_o), 32'(e.g));
      chk("idx",   32'(grant_idx_o), 32'(e.idx));
      chk("valid", 32'(grant_valid_o), 32'(e.v));
      chk("hold",  32'(hold_cnt_o), 32'(e.h));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_i = '0; done_i = 1'b0;
    // reset with all requesting, then first grant to 0
    step(0, 4'b1111, 0);
    step(0, 4'b1111, 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_hold", 32'(hold_cnt_o), 0);
    step(1, 4'b1111, 0);
    chk("first_grant", 32'(grant_o), 32'h1);
    chk("first_hold", 32'(hold_cnt_o), 1);

    // rotation with done pulses
    step(1, 4'b1111, 1); chk("rot1", 32'(grant_o), 32'h2);
    step(1, 4'b1111, 1); chk("rot2", 32'(grant_o), 32'h4);
    step(1, 4'b1111, 1); chk("rot3", 32'(grant_o), 32'h8);
    step(1, 4'b1111, 1); chk("rot4", 32'(grant_o), 32'h1);
    chk("rot_valid", 32'(grant_valid_o), 1);

    // timeout and self re-grant
    step(1, 4'b0100, 1); chk("to_start", 32'(grant_o), 32'h4);
    for (int i = 2; i <= MAX_HOLD; i++) step(1, 4'b0100, 0);
    chk("to_max", 32'(hold_cnt_o), MAX_HOLD);
    step(1, 4'b0100, 0);
    chk("to_regrant", 32'(grant_o), 32'h4);
    chk("to_hold1", 32'(hold_cnt_o), 1);

    // owner drops request, then done hands back
    step(1, 4'b0010, 1); chk("own1", 32'(grant_idx_o), 1);
    step(1, 4'b1010, 0);
    step(1, 4'b1000, 0);
    chk("drop_grant", 32'(grant_o), 32'h8);
    chk("drop_idx", 32'(grant_idx_o), 3);
    step(1, 4'b0010, 1); chk("back", 32'(grant_o), 32'h2);

    // release into idle, done in idle ignored, wrap from ptr=3
    step(1, 4'b0100, 1); chk("own2", 32'(grant_idx_o), 2);
    step(1, 4'b0000, 1);
    chk("idle_valid", 32'(grant_valid_o), 0);
    chk("idle_grant", 32'(grant_o), 0);
    step(1, 4'b0000, 1);
    step(1, 4'b0001, 0); chk("wrap", 32'(grant_o), 32'h1);

    // reset mid-tenure
    step(1, 4'b1000, 1); chk("own3", 32'(grant_idx_o), 3);
    for (int i = 0; i < 4; i++) step(1, 4'b1000, 0);
    chk("hold5", 32'(hold_cnt_o), 5);
    step(0, 4'b1111, 0);
    chk("mid_rst", 32'(grant_o), 0);
    step(1, 4'b1111, 0);
    chk("post_rst", 32'(grant_o), 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) != 0), N'($urandom), ($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
